conv_pixel_scheduler: RTL and testbench

- Sequences one depthwise_conv3x3_engine to compute every output channel of a standard (full-channel) convolution at a single output pixel.
- For each output channel it runs the engine once per input channel, sums the signed partial results and emits one feature word.
- Window and kernel data are staged by external muxes indexed by this block's channel selects.
- It replaces testbench-driven sequencing, so layer-0 pixel computation is self-timed in RTL.

---
 rtl/conv_pixel_scheduler.sv | 156 +++++++++++++++
 tb/tb_conv_pixel_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pixel_scheduler.sv
// conv_pixel_scheduler: drives one depthwise 3x3 engine IN_C times per output channel,
// sums the signed partials and emits one feature word per output channel of a pixel.
module conv_pixel_scheduler #(
   parameter int unsigned IN_C    = 3,
   parameter int unsigned OUT_C   = 32,
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned TIMEOUT = 64,
   localparam int unsigned OCW    = (OUT_C > 1) ? $clog2(OUT_C) : 1,
   localparam int unsigned ICW    = (IN_C > 1) ? $clog2(IN_C) : 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [OCW-1:0]   sel_out_ch,
   output logic [ICW-1:0]   sel_in_ch,
   output logic             eng_clear,
   output logic             eng_start,
   input  logic [31:0]      eng_result,
   input  logic             eng_valid,
   output logic             feat_valid,
   input  logic             feat_ready,
   output logic [ACC_W-1:0] feat_data,
   output logic [OCW-1:0]   feat_ch
);

   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   localparam logic [ICW-1:0]  LastIn  = ICW'(IN_C - 1);
   localparam logic [OCW-1:0]  LastOut = OCW'(OUT_C - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StStart,
      StWait,
      StAccum,
      StEmit,
      StDone
   } state_e;

   state_e            state_q;
   logic [ACC_W-1:0]  acc_q;
   logic [31:0]       result_q;
   logic [TmoW-1:0]   tmo_q;
   logic [ACC_W-1:0]  result_ext;
   logic [ACC_W-1:0]  acc_sum;

   // Engine partial is signed 32-bit: sign-extend or truncate to the accumulator width
   if (ACC_W > 32) begin : g_sext
      assign result_ext = {{(ACC_W - 32){result_q[31]}}, result_q};
   end else begin : g_trunc
      assign result_ext = result_q[ACC_W-1:0];
   end

   // Two's-complement wrap is intended; no saturation
   assign acc_sum = acc_q + result_ext;

   // Sequencer FSM; every output is registered and set on the transition into its state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         eng_clear  <= 1'b0;
         eng_start  <= 1'b0;
         feat_valid <= 1'b0;
         sel_out_ch <= '0;
         sel_in_ch  <= '0;
         feat_ch    <= '0;
         feat_data  <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         tmo_q      <= '0;
      end else begin
         eng_clear <= 1'b0;
         eng_start <= 1'b0;
         done      <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StClear;
                  sel_out_ch <= '0;
                  sel_in_ch  <= '0;
                  acc_q      <= '0;
                  error      <= 1'b0;
                  busy       <= 1'b1;
                  eng_clear  <= 1'b1;
               end
            end
            StClear: begin
               // Window/kernel muxes settle on sel_* during the clear cycle
               state_q   <= StStart;
               eng_start <= 1'b1;
            end
            StStart: begin
               state_q <= StWait;
               tmo_q   <= '0;
            end
            StWait: begin
               if (eng_valid) begin
                  result_q <= eng_result;
                  state_q  <= StAccum;
               end else if (tmo_q == TmoLast) begin
                  state_q <= StIdle;
                  error   <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TmoW'(1);
               end
            end
            StAccum: begin
               acc_q <= acc_sum;
               if (sel_in_ch == LastIn) begin
                  state_q    <= StEmit;
                  feat_valid <= 1'b1;
                  feat_data  <= acc_sum;
                  feat_ch    <= sel_out_ch;
               end else begin
                  sel_in_ch <= sel_in_ch + ICW'(1);
                  state_q   <= StClear;
                  eng_clear <= 1'b1;
               end
            end
            StEmit: begin
               if (feat_ready) begin
                  feat_valid <= 1'b0;
                  if (sel_out_ch == LastOut) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     sel_out_ch <= sel_out_ch + OCW'(1);
                     sel_in_ch  <= '0;
                     acc_q      <= '0;
                     state_q    <= StClear;
                     eng_clear  <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_pixel_scheduler.sv
// Bench for conv_pixel_scheduler: behavioural engine model, feature scoreboard,
// table-driven pixel jobs plus hand-written timeout and mid-job reset sequences.
module tb_conv_pixel_scheduler;

   localparam int IN_C    = 3;
   localparam int OUT_C   = 6;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 2;
   // start-to-done cycles with feat_ready high: OUT_C*(IN_C*(3+LAT)+1)+1
   localparam int JOB_CYC = OUT_C * (IN_C * (3 + LAT) + 1) + 1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [2:0]  sel_out_ch;
   logic [1:0]  sel_in_ch;
   logic        eng_clear, eng_start;
   logic [31:0] eng_result;
   logic        eng_valid;
   logic        feat_valid;
   logic        feat_ready = 1'b1;
   logic [31:0] feat_data;
   logic [2:0]  feat_ch;

   always #5 clock = ~clock;

   conv_pixel_scheduler #(
      .IN_C    (IN_C),
      .OUT_C   (OUT_C),
      .ACC_W   (32),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .sel_out_ch (sel_out_ch),
      .sel_in_ch  (sel_in_ch),
      .eng_clear  (eng_clear),
      .eng_start  (eng_start),
      .eng_result (eng_result),
      .eng_valid  (eng_valid),
      .feat_valid (feat_valid),
      .feat_ready (feat_ready),
      .feat_data  (feat_data),
      .feat_ch    (feat_ch)
   );

   typedef struct {
      int a0, a1, a2;    // ch0 partials (ch>=2 uses these times ch)
      int b0, b1, b2;    // ch1 partials
      int exp0, exp1;    // hand-computed features for ch0 and ch1
      int stall;         // feat_ready low cycles during first EMIT
      bit poke;          // extra start pulses mid-job and in the done cycle
   } vec_t;

   typedef struct {
      int          ch;
      logic [31:0] data;
   } sb_t;

   int          n_checks = 0;
   int          n_fail = 0;
   vec_t        vecs[4];
   sb_t         sb[$];
   logic [31:0] partial[OUT_C][IN_C];
   bit          eng_mute = 1'b0;
   int          pend;
   logic [31:0] pres;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Engine model: valid exactly LAT cycles after eng_start, result picked by the selects
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend       <= 0;
         pres       <= '0;
         eng_valid  <= 1'b0;
         eng_result <= '0;
      end else begin
         eng_valid <= 1'b0;
         if (eng_start && !eng_mute) begin
            pend <= LAT - 1;
            pres <= partial[sel_out_ch][sel_in_ch];
         end else if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
               eng_valid  <= 1'b1;
               eng_result <= pres;
            end
         end
      end
   end

   task automatic load(input vec_t v);
      int a[3];
      int b[3];
      sb_t e;
      a = '{v.a0, v.a1, v.a2};
      b = '{v.b0, v.b1, v.b2};
      sb.delete();
      for (int oc = 0; oc < OUT_C; oc++) begin
         int sum;
         sum = 0;
         for (int ic = 0; ic < IN_C; ic++) begin
            int p;
            p = (oc == 0) ? a[ic] : (oc == 1) ? b[ic] : a[ic] * oc;
            partial[oc][ic] = p;
            sum += p;
         end
         e.ch   = oc;
         e.data = (oc == 0) ? v.exp0 : (oc == 1) ? v.exp1 : sum;
         sb.push_back(e);
      end
   endtask

   task automatic score(input string tag);
      sb_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s unexpected feature: got ch %0d data 0x%0h, expected none",
                  tag, feat_ch, feat_data);
      end else begin
         e = sb.pop_front();
         check({tag, " feat_ch"}, 32'(feat_ch), e.ch);
         check({tag, " feat_data"}, feat_data, e.data);
      end
   endtask

   task automatic run_job(input int vi);
      vec_t        v;
      int          cyc, clears, starts, overlap, xfers, stall_left, stalled, unstable, idle_bad;
      bit          done_seen, held;
      logic [31:0] held_d;
      logic [2:0]  held_c;
      string       tag;
      v = vecs[vi];
      tag = $sformatf("job%0d", vi);
      cyc = 0; clears = 0; starts = 0; overlap = 0; xfers = 0;
      stalled = 0; unstable = 0; idle_bad = 0;
      done_seen = 1'b0; held = 1'b0; held_d = '0; held_c = '0;
      stall_left = v.stall;
      load(v);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      check({tag, " busy after start"}, 32'(busy), 1);
      check({tag, " error cleared by start"}, 32'(error), 0);
      while (!done_seen && cyc < 400) begin
         clears += int'(eng_clear);
         starts += int'(eng_start);
         if (eng_clear && eng_start) overlap++;
         if (held && feat_valid && ({feat_data, feat_ch} != {held_d, held_c})) unstable++;
         held = 1'b0;
         if (feat_valid && stall_left > 0) begin
            feat_ready = 1'b0;
            stall_left--;
            stalled++;
            held   = 1'b1;
            held_d = feat_data;
            held_c = feat_ch;
         end else begin
            feat_ready = 1'b1;
         end
         if (feat_valid && feat_ready) begin
            xfers++;
            score(tag);
         end
         start = (v.poke && cyc == 40);
         if (done) begin
            done_seen = 1'b1;
         end else begin
            @(negedge clock);
            cyc++;
         end
      end
      check({tag, " done seen"}, 32'(done_seen), 1);
      check({tag, " start-to-done cycles"}, cyc, JOB_CYC + v.stall);
      check({tag, " busy low in done cycle"}, 32'(busy), 0);
      check({tag, " eng_clear cycles"}, clears, OUT_C * IN_C);
      check({tag, " eng_start cycles"}, starts, OUT_C * IN_C);
      check({tag, " clear/start overlap"}, overlap, 0);
      check({tag, " feature transfers"}, xfers, OUT_C);
      check({tag, " scoreboard left"}, sb.size(), 0);
      check({tag, " error after job"}, 32'(error), 0);
      if (v.stall > 0) begin
         check({tag, " stalled cycles"}, stalled, v.stall);
         check({tag, " stall stability"}, unstable, 0);
      end
      // A start in the done cycle must be ignored
      start = v.poke;
      @(negedge clock);
      start = 1'b0;
      check({tag, " done one cycle"}, 32'(done), 0);
      for (int i = 0; i < 3; i++) begin
         if (busy || eng_clear || eng_start) idle_bad++;
         @(negedge clock);
      end
      check({tag, " idle after done"}, idle_bad, 0);
   endtask

   initial begin
      int cyc, bad_fv, bad_done, xfers;
      bit found;

      vecs[0] = '{10, -3, 5, -100, -200, 50, 12, -250, 0, 1'b1};
      vecs[1] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, -1, -1, -1,
                  32'h7FFFFFFD, -3, 0, 1'b0};
      vecs[2] = '{1, 2, 3, int'(32'h80000000), int'(32'h80000000), 0, 6, 0, 7, 1'b0};
      vecs[3] = '{0, 0, 0, -1, 1, -5, 0, -5, 3, 1'b1};
      for (int oc = 0; oc < OUT_C; oc++)
         for (int ic = 0; ic < IN_C; ic++) partial[oc][ic] = '0;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset flags", 32'({busy, done, error, eng_clear, eng_start, feat_valid}), 0);
      check("reset selects", 32'({sel_out_ch, sel_in_ch, feat_ch}), 0);
      check("reset feat_data", feat_data, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Table-driven pixel jobs
      run_job(0);
      run_job(1);
      run_job(2);

      // Engine never answers: timeout after 64 WAIT cycles
      eng_mute = 1'b1;
      load(vecs[0]);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1; bad_fv = 0; bad_done = 0;
      while (!error && cyc < 200) begin
         if (feat_valid) bad_fv++;
         if (done) bad_done++;
         @(negedge clock);
         cyc++;
      end
      check("timeout error set", 32'(error), 1);
      check("timeout cycle", cyc, 3 + TIMEOUT);
      check("timeout busy", 32'(busy), 0);
      check("timeout no feature", bad_fv, 0);
      check("timeout no done", bad_done, 0);
      repeat (3) @(negedge clock);
      check("timeout error sticky", 32'(error), 1);
      check("timeout still idle", 32'({busy, done, feat_valid}), 0);
      eng_mute = 1'b0;
      run_job(3);

      // Reset in WAIT of output channel 5
      load(vecs[0]);
      feat_ready = 1'b1;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1; xfers = 0; found = 1'b0;
      while (!found && cyc < 400) begin
         if (feat_valid) begin
            xfers++;
            score("prereset");
         end
         if (eng_start && sel_out_ch == 3'd5) found = 1'b1;
         @(negedge clock);
         cyc++;
      end
      check("reached ch5 start", 32'(found), 1);
      check("features before reset", xfers, 5);
      reset_n = 1'b0;
      #1;
      check("async reset flags", 32'({busy, done, error, eng_clear, eng_start, feat_valid}), 0);
      check("async reset selects", 32'({sel_out_ch, sel_in_ch, feat_ch}), 0);
      check("async reset feat_data", feat_data, 0);
      repeat (2) @(negedge clock);
      check("no feature in reset", 32'(feat_valid), 0);
      reset_n = 1'b1;
      @(negedge clock);
      run_job(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
